// File: rtl/add_seq_pkg.sv
// Shared types and default sizing for the chunked sequential adder (add_seq).
package add_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_CHUNK = 16;

endpackage

// File: rtl/add_chunk.sv
// W-bit combinational adder slice: sum, carry-out and carry into the MSB.
module add_chunk #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         cmsb
);

   logic [W:0] w_full;

   assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign sum    = w_full[W-1:0];
   assign cout   = w_full[W];
   // Sum MSB is a^b^c at that bit, so the carry into it falls out by xor.
   assign cmsb   = w_full[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/add_seq.sv
// Multi-cycle adder: CHUNK bits per cycle, result NCHUNK cycles after accept, held until out_ready.
// ADD_SEQ_OVF_EN adds out_ovf (signed overflow), captured and held alongside out_cout.
module add_seq
   import add_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
`ifdef ADD_SEQ_OVF_EN
   output logic             out_ovf,
`endif
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_cfg
         $error("add_seq: WIDTH must be an integer multiple of CHUNK");
      end
   endgenerate

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [IDX_W-1:0] r_idx;
   logic             r_carry;
   logic             r_cout;
   logic             r_valid;

   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK-1:0] w_chunk_sum;
   logic             w_chunk_cout;
   logic             w_chunk_cmsb;

   assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
   assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

   add_chunk #(.W(CHUNK)) u_add_chunk (
      .a    (w_a_chunk),
      .b    (w_b_chunk),
      .cin  (r_carry),
      .sum  (w_chunk_sum),
      .cout (w_chunk_cout),
      .cmsb (w_chunk_cmsb)
   );

`ifdef ADD_SEQ_OVF_EN
   logic r_ovf;

   // Overflow only means anything on the top chunk, so it is sampled with out_cout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == RUN && r_idx == LAST_IDX) begin
         r_ovf <= w_chunk_cmsb ^ w_chunk_cout;
      end
   end

   assign out_ovf = r_ovf;
`else
   logic w_unused_cmsb;
   assign w_unused_cmsb = w_chunk_cmsb;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_carry <= in_cin;
                  r_idx   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_sum[r_idx*CHUNK +: CHUNK] <= w_chunk_sum;
               r_carry                     <= w_chunk_cout;
               if (r_idx == LAST_IDX) begin
                  r_cout  <= w_chunk_cout;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = r_valid;
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq: directed corner cases plus randomized back-to-back traffic.
module tb_add_seq;

   localparam int W     = 64;
   localparam int NCH   = 4;
   localparam int N_RND = 1000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;
`ifdef ADD_SEQ_OVF_EN
   logic         out_ovf;
`endif

   int           n_tests = 0;
   int           n_fail  = 0;
   int           n_recv  = 0;
   logic [65:0]  sb_q[$];
   logic [65:0]  mon_exp;

   always #5 clk = ~clk;

   add_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
`ifdef ADD_SEQ_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .busy      (busy)
   );

   // {ovf, cout, sum}; ovf from operand/result sign rule, independent of carries.
   function automatic logic [65:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
      logic [64:0] full;
      logic        ovf;
      full = {1'b0, a} + {1'b0, b} + {64'd0, c};
      ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return {ovf, full};
   endfunction

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (in_valid && in_ready)
            sb_q.push_back(model(in_a, in_b, in_cin));
         if (out_valid && out_ready) begin
            chk("sb_nonempty", 66'(sb_q.size() != 0), 66'd1);
            if (sb_q.size() != 0) begin
               mon_exp = sb_q.pop_front();
               chk("sb_result", {1'b0, out_cout, out_sum}, {1'b0, mon_exp[64:0]});
`ifdef ADD_SEQ_OVF_EN
               chk("sb_ovf", 66'(out_ovf), 66'(mon_exp[65]));
`endif
               n_recv++;
            end
         end
      end
   end

   // Called 2 time units after a rising edge with the DUT idle.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      chk("in_ready_idle", 66'(in_ready), 66'd1);
      in_a     = a;
      in_b     = b;
      in_cin   = c;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc, output logic busy_all);
      cyc      = 0;
      busy_all = busy;
      while (!out_valid && cyc < 50) begin
         @(posedge clk);
         #2;
         cyc++;
         busy_all = busy_all & busy;
      end
      chk("wait_valid_timeout", 66'(out_valid), 66'd1);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int          cyc;
      logic        bsy;
      int          sent;
      int          guard;
      int          recv0;
      logic        acc;
      logic [W-1:0] ones;

      ones      = '1;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      chk("rst_out_valid", 66'(out_valid), 66'd0);
      chk("rst_busy", 66'(busy), 66'd0);
      chk("rst_sum_cout", {1'b0, out_cout, out_sum}, 66'd0);
      chk("rst_in_ready", 66'(in_ready), 66'd1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      step();

      // Basic add: latency and busy.
      send(64'd1, 64'd2, 1'b0);
      wait_valid(cyc, bsy);
      chk("t1_latency", 66'(cyc), 66'(NCH));
      chk("t1_busy", 66'(bsy), 66'd1);
      chk("t1_sum", 66'(out_sum), 66'd3);
      chk("t1_cout", 66'(out_cout), 66'd0);
      step();
      chk("t1_ready_after", 66'(in_ready), 66'd1);
      chk("t1_valid_after", 66'(out_valid), 66'd0);

      // Carry across every chunk boundary.
      send(ones, 64'd0, 1'b1);
      wait_valid(cyc, bsy);
      chk("t2_sum", 66'(out_sum), 66'd0);
      chk("t2_cout", 66'(out_cout), 66'd1);
      step();

      // Backpressure with ignored in_valid.
      out_ready = 1'b0;
      send(64'd5, 64'd7, 1'b0);
      wait_valid(cyc, bsy);
      for (int i = 0; i < 6; i++) begin
         chk("t3_hold_sum", 66'(out_sum), 66'd12);
         chk("t3_hold_valid", 66'(out_valid), 66'd1);
         chk("t3_hold_ready", 66'(in_ready), 66'd0);
         in_valid = 1'b1;
         in_a     = 64'd99;
         in_b     = 64'd1;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("t3_ready_after", 66'(in_ready), 66'd1);
      chk("t3_valid_after", 66'(out_valid), 66'd0);
      chk("t3_no_extra", 66'(sb_q.size()), 66'd0);

      // Reset in the middle of RUN at chunk index 2.
      send(64'd3, 64'd4, 1'b0);
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      chk("t4_rst_valid", 66'(out_valid), 66'd0);
      chk("t4_rst_busy", 66'(busy), 66'd0);
      chk("t4_rst_sum_cout", {1'b0, out_cout, out_sum}, 66'd0);
      chk("t4_rst_ready", 66'(in_ready), 66'd1);
`ifdef ADD_SEQ_OVF_EN
      chk("t4_rst_ovf", 66'(out_ovf), 66'd0);
`endif
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      send(64'd10, 64'd20, 1'b0);
      wait_valid(cyc, bsy);
      chk("t4_sum", 66'(out_sum), 66'd30);
      step();

      // Signed overflow corners.
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      wait_valid(cyc, bsy);
      chk("t5a_sum", 66'(out_sum), 66'h8000_0000_0000_0000);
      chk("t5a_cout", 66'(out_cout), 66'd0);
`ifdef ADD_SEQ_OVF_EN
      chk("t5a_ovf", 66'(out_ovf), 66'd1);
`endif
      step();
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      wait_valid(cyc, bsy);
      chk("t5b_sum", 66'(out_sum), 66'd0);
      chk("t5b_cout", 66'(out_cout), 66'd1);
`ifdef ADD_SEQ_OVF_EN
      chk("t5b_ovf", 66'(out_ovf), 66'd1);
`endif
      step();

      // Random traffic with random consumer stalls.
      recv0 = n_recv;
      sent  = 0;
      guard = 0;
      while (sent < N_RND && guard < 60000) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_a     = ($urandom_range(0, 7) == 0) ? ones : {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            in_cin   = 1'($urandom_range(0, 1));
         end
         out_ready = 1'($urandom_range(0, 1));
         acc       = in_valid && in_ready;
         step();
         guard++;
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      chk("rand_sent", 66'(sent), 66'(N_RND));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard     = 0;
      while ((sb_q.size() != 0 || busy) && guard < 100) begin
         step();
         guard++;
      end
      chk("rand_drain", 66'(sb_q.size()), 66'd0);
      chk("rand_recv_count", 66'(n_recv - recv0), 66'(N_RND));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
